// File: rtl/xy_step_pulse_gen_if.sv
// Register-side bundle for the XY step pulse generator.
// Carries the stepper registers in and the driver pins and status out.
interface xy_step_pulse_gen_if #(
  parameter int POS_WIDTH = 32
);
  logic                 en;
  logic [31:0]          step_x_dir;
  logic [31:0]          step_y_dir;
  logic [31:0]          step_x_speed;
  logic [31:0]          step_y_speed;
  logic                 x_step;
  logic                 x_dir;
  logic                 y_step;
  logic                 y_dir;
  logic [POS_WIDTH-1:0] x_pos;
  logic [POS_WIDTH-1:0] y_pos;
  logic                 x_busy;
  logic                 y_busy;

  modport master (
    output en, step_x_dir, step_y_dir, step_x_speed, step_y_speed,
    input  x_step, x_dir, y_step, y_dir, x_pos, y_pos, x_busy, y_busy
  );

  modport slave (
    input  en, step_x_dir, step_y_dir, step_x_speed, step_y_speed,
    output x_step, x_dir, y_step, y_dir, x_pos, y_pos, x_busy, y_busy
  );
endinterface

// File: rtl/xy_step_pulse_gen.sv
// Two independent step/dir generators (X, Y) with direction setup, minimum pulse
// width, per-period register re-sampling and signed step position tracking.
module xy_step_pulse_gen #(
  parameter int PULSE_CYCLES     = 4,
  parameter int DIR_SETUP_CYCLES = 3,
  parameter int POS_WIDTH        = 32
) (
  input logic                clock,
  input logic                reset,
  xy_step_pulse_gen_if.slave bus
);
  localparam int CNT_MAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [31:0]      MIN_PER    = 32'(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(DIR_SETUP_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_e;

  // Index 0 is the X axis, index 1 the Y axis.
  state_e               state_q [2];
  state_e               state_d [2];
  logic [1:0]           step_q, step_d;
  logic [1:0]           dir_q, dir_d;
  logic [1:0]           busy_q, busy_d;
  logic [POS_WIDTH-1:0] pos_q [2];
  logic [POS_WIDTH-1:0] pos_d [2];
  logic [31:0]          per_q [2];
  logic [31:0]          per_d [2];
  logic [31:0]          prd_q [2];
  logic [31:0]          prd_d [2];
  logic [CNT_W-1:0]     cnt_q [2];
  logic [CNT_W-1:0]     cnt_d [2];

  logic [1:0]  dir_in;
  logic [31:0] speed_in [2];
  logic [1:0]  sample, start;
  logic        unused_dir_bits;

  assign dir_in          = {bus.step_y_dir[0], bus.step_x_dir[0]};
  assign speed_in[0]     = bus.step_x_speed;
  assign speed_in[1]     = bus.step_y_speed;
  assign unused_dir_bits = ^{bus.step_x_dir[31:1], bus.step_y_dir[31:1]};

  always_comb begin
    sample = '0;
    start  = '0;
    for (int unsigned a = 0; a < 2; a++) begin
      sample[a] = (state_q[a] == IDLE) || (state_q[a] == GAP && prd_q[a] == '0);
      start[a]  = sample[a] && bus.en && (speed_in[a] != '0);
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned a = 0; a < 2; a++) begin
      if (reset) state_q[a] <= IDLE;
      else       state_q[a] <= state_d[a];
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      unique case (state_q[a])
        IDLE, GAP: begin
          if (sample[a]) begin
            if (!start[a])                  state_d[a] = IDLE;
            else if (dir_in[a] == dir_q[a]) state_d[a] = PULSE;
            else                            state_d[a] = SETUP;
          end
        end
        SETUP:   if (cnt_q[a] == CNT_W'(1)) state_d[a] = PULSE;
        PULSE:   if (cnt_q[a] == '0)        state_d[a] = GAP;
        default: state_d[a] = IDLE;
      endcase
    end
  end

  // The period counter runs through PULSE and GAP so that the rise-to-rise
  // spacing equals the latched period; cnt is shared by SETUP and PULSE.
  always_comb begin
    step_d = '0;
    busy_d = '0;
    dir_d  = dir_q;
    for (int unsigned a = 0; a < 2; a++) begin
      step_d[a] = (state_d[a] == PULSE);
      busy_d[a] = (state_d[a] != IDLE);
      pos_d[a]  = pos_q[a];
      per_d[a]  = per_q[a];
      prd_d[a]  = prd_q[a];
      cnt_d[a]  = cnt_q[a];
      if ((state_q[a] == PULSE || state_q[a] == GAP) && prd_q[a] != '0)
        prd_d[a] = prd_q[a] - 32'd1;
      if (state_q[a] == SETUP || (state_q[a] == PULSE && cnt_q[a] != '0))
        cnt_d[a] = cnt_q[a] - CNT_W'(1);
      if (start[a]) begin
        per_d[a] = (speed_in[a] < MIN_PER) ? MIN_PER : speed_in[a];
        if (dir_in[a] != dir_q[a]) begin
          dir_d[a] = dir_in[a];
          cnt_d[a] = SETUP_INIT;
        end
      end
      if (state_d[a] == PULSE && state_q[a] != PULSE) begin
        pos_d[a] = dir_q[a] ? pos_q[a] + POS_WIDTH'(1) : pos_q[a] - POS_WIDTH'(1);
        prd_d[a] = per_d[a] - 32'd1;
        cnt_d[a] = PULSE_LAST;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= '0;
      dir_q  <= '0;
      busy_q <= '0;
      for (int unsigned a = 0; a < 2; a++) begin
        pos_q[a] <= '0;
        per_q[a] <= '0;
        prd_q[a] <= '0;
        cnt_q[a] <= '0;
      end
    end else begin
      step_q <= step_d;
      dir_q  <= dir_d;
      busy_q <= busy_d;
      for (int unsigned a = 0; a < 2; a++) begin
        pos_q[a] <= pos_d[a];
        per_q[a] <= per_d[a];
        prd_q[a] <= prd_d[a];
        cnt_q[a] <= cnt_d[a];
      end
    end
  end

  assign bus.x_step = step_q[0];
  assign bus.y_step = step_q[1];
  assign bus.x_dir  = dir_q[0];
  assign bus.y_dir  = dir_q[1];
  assign bus.x_busy = busy_q[0];
  assign bus.y_busy = busy_q[1];
  assign bus.x_pos  = pos_q[0];
  assign bus.y_pos  = pos_q[1];
endmodule

// File: tb/tb_xy_step_pulse_gen.sv
// Bench for xy_step_pulse_gen: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized register traffic.
module tb_xy_step_pulse_gen;
  localparam int P = 4;
  localparam int D = 3;

  logic clock = 1'b0;
  logic reset;

  xy_step_pulse_gen_if #(.POS_WIDTH(32)) bus ();

  xy_step_pulse_gen #(
    .PULSE_CYCLES    (P),
    .DIR_SETUP_CYCLES(D),
    .POS_WIDTH       (32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: each axis is described by when its next rise happens and
  // when its next sample edge is, derived directly from the timing rules.
  longint      cyc = 0;
  longint      last_rst = 0;
  bit          m_valid = 1'b0;
  bit          m_idle [2] = '{1'b1, 1'b1};
  bit          m_dir  [2] = '{1'b0, 1'b0};
  logic [31:0] m_pos  [2] = '{32'd0, 32'd0};
  longint      m_rise [2] = '{-1000, -1000};
  longint      m_samp [2] = '{0, 0};
  longint      m_per  [2] = '{0, 0};
  bit          m_step [2] = '{1'b0, 1'b0};
  bit          m_din;
  longint      m_spd;

  always @(posedge clock) begin
    cyc++;
    for (int a = 0; a < 2; a++) begin
      m_din = (a == 0) ? bus.step_x_dir[0] : bus.step_y_dir[0];
      m_spd = (a == 0) ? longint'(bus.step_x_speed) : longint'(bus.step_y_speed);
      if (reset) begin
        m_idle[a] = 1'b1;
        m_dir[a]  = 1'b0;
        m_pos[a]  = 32'd0;
        m_rise[a] = -1000;
      end else begin
        if (m_idle[a] || cyc == m_samp[a]) begin
          if (bus.en && m_spd != 0) begin
            m_per[a]  = (m_spd < P + 1) ? longint'(P + 1) : m_spd;
            m_idle[a] = 1'b0;
            if (m_din == m_dir[a]) m_rise[a] = cyc;
            else begin
              m_dir[a]  = m_din;
              m_rise[a] = cyc + D;
            end
            m_samp[a] = m_rise[a] + m_per[a];
          end else begin
            m_idle[a] = 1'b1;
          end
        end
        if (!m_idle[a] && cyc == m_rise[a])
          m_pos[a] = m_dir[a] ? m_pos[a] + 32'd1 : m_pos[a] - 32'd1;
      end
      m_step[a] = !m_idle[a] && cyc >= m_rise[a] && cyc < m_rise[a] + P;
    end
    if (reset) begin
      m_valid  = 1'b1;
      last_rst = cyc;
    end
  end

  // Per-cycle comparison plus rise/width bookkeeping for the directed checks.
  int     rises_x = 0, rises_y = 0;
  longint last_rise_x = -1, prev_rise_x = -1, last_rise_y = -1, width_x = 0;
  bit     px = 1'b0, py = 1'b0;

  always @(posedge clock) begin
    #1;
    if (m_valid) begin
      chk("x_step_dir_busy", {29'd0, bus.x_step, bus.x_dir, bus.x_busy},
          {29'd0, m_step[0], m_dir[0], !m_idle[0]});
      chk("x_pos", bus.x_pos, m_pos[0]);
      chk("y_step_dir_busy", {29'd0, bus.y_step, bus.y_dir, bus.y_busy},
          {29'd0, m_step[1], m_dir[1], !m_idle[1]});
      chk("y_pos", bus.y_pos, m_pos[1]);
    end
    if (bus.x_step === 1'b1 && !px) begin
      rises_x++;
      prev_rise_x = last_rise_x;
      last_rise_x = cyc;
    end
    if (bus.x_step !== 1'b1 && px) width_x = cyc - last_rise_x;
    px = (bus.x_step === 1'b1);
    if (bus.y_step === 1'b1 && !py) begin
      rises_y++;
      last_rise_y = cyc;
    end
    py = (bus.y_step === 1'b1);
  end

  task automatic wait_rises_x(input int more, input int budget);
    int target;
    target = rises_x + more;
    for (int i = 0; i < budget && rises_x < target; i++) @(negedge clock);
    chk("wait_rise_x", rises_x, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int     saved;
  longint start_edge;

  initial begin
    reset            = 1'b1;
    bus.en           = 1'b0;
    bus.step_x_dir   = '0;
    bus.step_y_dir   = '0;
    bus.step_x_speed = '0;
    bus.step_y_speed = '0;
    repeat (3) @(negedge clock);
    chk("rst_x_step", {31'd0, bus.x_step}, 32'd0);
    chk("rst_x_dir",  {31'd0, bus.x_dir},  32'd0);
    chk("rst_x_busy", {31'd0, bus.x_busy}, 32'd0);
    chk("rst_x_pos",  bus.x_pos, 32'd0);
    chk("rst_y_pos",  bus.y_pos, 32'd0);

    // Steady run: dir differs from the reset dir, so a setup precedes the first rise.
    bus.step_x_dir   = 32'd1;
    bus.step_x_speed = 32'd10;
    bus.en           = 1'b1;
    reset            = 1'b0;
    wait_rises_x(1, 20);
    chk("first_rise_latency", 32'(last_rise_x - last_rst), 32'd4);
    wait_rises_x(4, 60);
    chk("steady_spacing", 32'(last_rise_x - prev_rise_x), 32'd10);
    chk("steady_width", 32'(width_x), 32'd4);
    chk("steady_pos", bus.x_pos, 32'd5);
    chk("steady_dir", {31'd0, bus.x_dir}, 32'd1);

    // Reversal requested mid-gap.
    repeat (6) @(negedge clock);
    bus.step_x_dir = 32'd0;
    wait_rises_x(1, 30);
    chk("reverse_spacing", 32'(last_rise_x - prev_rise_x), 32'd13);
    chk("reverse_dir", {31'd0, bus.x_dir}, 32'd0);
    chk("reverse_pos", bus.x_pos, 32'd4);

    // Clamp: speed 2 is raised to PULSE_CYCLES+1.
    bus.step_x_dir   = 32'd1;
    bus.step_x_speed = 32'd2;
    wait_rises_x(3, 60);
    chk("clamp_spacing", 32'(last_rise_x - prev_rise_x), 32'd5);
    chk("clamp_width", 32'(width_x), 32'd4);
    chk("clamp_pos", bus.x_pos, 32'd7);

    // Reset while the step pin is high.
    chk("pre_reset_step", {31'd0, bus.x_step}, 32'd1);
    reset            = 1'b1;
    bus.step_x_speed = 32'd10;
    @(negedge clock);
    chk("midrst_step", {31'd0, bus.x_step}, 32'd0);
    chk("midrst_dir",  {31'd0, bus.x_dir},  32'd0);
    chk("midrst_pos",  bus.x_pos, 32'd0);
    chk("midrst_busy", {31'd0, bus.x_busy}, 32'd0);
    reset = 1'b0;
    wait_rises_x(1, 20);
    chk("post_rst_latency", 32'(last_rise_x - last_rst), 32'd4);

    // Enable drop one cycle after a rise.
    @(negedge clock);
    bus.en = 1'b0;
    repeat (16) @(negedge clock);
    chk("endrop_width", 32'(width_x), 32'd4);
    chk("endrop_busy", {31'd0, bus.x_busy}, 32'd0);
    chk("endrop_pos", bus.x_pos, 32'd1);

    // Speed 0 never starts motion.
    saved            = rises_x;
    bus.en           = 1'b1;
    bus.step_x_speed = 32'd0;
    repeat (20) @(negedge clock);
    chk("speed0_busy", {31'd0, bus.x_busy}, 32'd0);
    chk("speed0_rises", rises_x, saved);
    chk("speed0_pos", bus.x_pos, 32'd1);

    // Dual axis from a common start with both dirs already matching.
    reset = 1'b1;
    @(negedge clock);
    reset            = 1'b0;
    bus.step_x_speed = 32'd10;
    wait_rises_x(2, 40);
    bus.en = 1'b0;
    repeat (20) @(negedge clock);
    chk("dual_base_pos", bus.x_pos, 32'd2);
    chk("dual_base_busy", {31'd0, bus.x_busy}, 32'd0);
    bus.step_y_dir   = 32'd0;
    bus.step_y_speed = 32'd15;
    bus.en           = 1'b1;
    start_edge       = cyc + 1;
    @(negedge clock);
    chk("dual_x_first", 32'(last_rise_x), 32'(start_edge));
    chk("dual_y_first", 32'(last_rise_y), 32'(start_edge));
    repeat (149) @(negedge clock);
    chk("dual_x_pos", bus.x_pos, 32'd17);
    chk("dual_y_pos", bus.y_pos, -32'sd10);
    chk("dual_y_rises", rises_y, 32'd10);

    // Randomized register traffic, including ignored upper dir bits and resets.
    for (int it = 0; it < 120; it++) begin
      bus.en           = ($urandom_range(0, 5) != 0);
      bus.step_x_dir   = $urandom;
      bus.step_y_dir   = $urandom;
      bus.step_x_speed = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 14));
      bus.step_y_speed = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 30)) @(negedge clock);
    end
    bus.en = 1'b0;
    repeat (30) @(negedge clock);
    chk("final_x_idle", {31'd0, bus.x_busy}, 32'd0);
    chk("final_y_idle", {31'd0, bus.y_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
